// File: rtl/atm_f7_port_ctrl.sv
// rtl/atm_f7_port_ctrl.sv - Z80 initiator for the ATM xxF7 paging ports with shadow readback
module atm_f7_port_ctrl (
   input  logic        rst_n,
   input  logic        fclk,
   input  logic        zpos,
   input  logic        zneg,
   input  logic [15:0] za,
   input  logic [7:0]  zd,
   input  logic        iorq_n,
   input  logic        rd_n,
   input  logic        wr_n,
   input  logic        m1_n,
   input  logic        pent1m_ROM,
   input  logic        shadow_en,
   output logic        atmF7_wr,
   output logic [15:0] f7_addr,
   output logic [7:0]  f7_data,
   output logic [7:0]  rd_data,
   output logic        rd_ena
);
   typedef enum logic [1:0] {IDLE = 2'd0, STROBE = 2'd1, HOLD = 2'd2} state_t;

   state_t      state_q, state_d;
   logic        wq_s_q, wq_s_d;
   logic        map_q, map_d;
   logic        atmf7_wr_q, atmf7_wr_d;
   logic [15:0] f7_addr_q, f7_addr_d;
   logic [7:0]  f7_data_q, f7_data_d;
   logic        rd_ena_q, rd_ena_d;
   logic [7:0]  rd_data_q, rd_data_d;
   logic [7:0]  shadow_q [8];
   logic [7:0]  shadow_d [8];
   logic        hit, wq, rq;
   logic        zneg_unused;

   assign zneg_unused = zneg;

   // Reset bytes reproduce the pager reset state when written back through xFF7
   function automatic logic [7:0] shadow_init(input logic [2:0] idx);
      case (idx)
         3'd0:       shadow_init = 8'h81;
         3'd1:       shadow_init = 8'h83;
         3'd2, 3'd3: shadow_init = 8'h7A;
         3'd4, 3'd5: shadow_init = 8'h7D;
         default:    shadow_init = 8'hFF;
      endcase
   endfunction

   assign hit = (za[7:0] == 8'hF7) && (za[13:12] == 2'b11) && (za[10:8] == 3'b111);
   assign wq  = hit && !iorq_n && !wr_n && m1_n;
   assign rq  = hit && !iorq_n && !rd_n && m1_n && shadow_en;

   always_comb begin
      wq_s_d    = zpos ? wq : wq_s_q;
      state_d   = state_q;
      f7_addr_d = f7_addr_q;
      f7_data_d = f7_data_q;
      map_d     = map_q;
      shadow_d  = shadow_q;
      case (state_q)
         IDLE: begin
            if (wq_s_q) begin
               state_d   = STROBE;
               f7_addr_d = za;
               f7_data_d = zd;
               map_d     = pent1m_ROM;
            end
         end
         STROBE: begin
            state_d = HOLD;
            shadow_d[{f7_addr_q[15:14], map_q}] = f7_data_q;
         end
         HOLD: begin
            // Stay here until the sampled write drops so a stretched cycle strobes once
            if (!wq_s_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      atmf7_wr_d = (state_q == STROBE);
      rd_ena_d   = rq;
      rd_data_d  = shadow_q[{za[15:14], pent1m_ROM}];
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wq_s_q     <= 1'b0;
         map_q      <= 1'b0;
         atmf7_wr_q <= 1'b0;
         f7_addr_q  <= 16'h0000;
         f7_data_q  <= 8'h00;
         rd_ena_q   <= 1'b0;
         rd_data_q  <= 8'h00;
         for (int i = 0; i < 8; i++) shadow_q[i] <= shadow_init(i[2:0]);
      end else begin
         state_q    <= state_d;
         wq_s_q     <= wq_s_d;
         map_q      <= map_d;
         atmf7_wr_q <= atmf7_wr_d;
         f7_addr_q  <= f7_addr_d;
         f7_data_q  <= f7_data_d;
         rd_ena_q   <= rd_ena_d;
         rd_data_q  <= rd_data_d;
         shadow_q   <= shadow_d;
      end
   end

   assign atmF7_wr = atmf7_wr_q;
   assign f7_addr  = f7_addr_q;
   assign f7_data  = f7_data_q;
   assign rd_ena   = rd_ena_q;
   assign rd_data  = rd_data_q;
endmodule

// File: tb/tb_atm_f7_port_ctrl.sv
// tb/tb_atm_f7_port_ctrl.sv - randomized self-checking bench for atm_f7_port_ctrl
module tb_atm_f7_port_ctrl;
   logic        rst_n = 1'b0, fclk = 1'b0, zpos = 1'b0, zneg = 1'b0;
   logic [15:0] za = 16'h0000;
   logic [7:0]  zd = 8'h00;
   logic        iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, m1_n = 1'b1;
   logic        pent1m_ROM = 1'b0, shadow_en = 1'b0;
   logic        atmF7_wr, rd_ena;
   logic [15:0] f7_addr;
   logic [7:0]  f7_data, rd_data;

   int cyc = 0, n_chk = 0, n_fail = 0, n_strobe = 0, strobe_cyc = 0, n_rdena = 0;
   logic [7:0] sh [8];

   atm_f7_port_ctrl dut (
      .rst_n(rst_n), .fclk(fclk), .zpos(zpos), .zneg(zneg), .za(za), .zd(zd),
      .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
      .pent1m_ROM(pent1m_ROM), .shadow_en(shadow_en), .atmF7_wr(atmF7_wr),
      .f7_addr(f7_addr), .f7_data(f7_data), .rd_data(rd_data), .rd_ena(rd_ena)
   );

   always #5 fclk = ~fclk;
   always @(posedge fclk) cyc++;
   always @(negedge fclk) begin
      zpos = (cyc % 4 == 0);
      zneg = (cyc % 4 == 2);
   end
   always @(negedge fclk) begin
      if (atmF7_wr) begin
         n_strobe++;
         strobe_cyc = cyc;
      end
      if (rd_ena) n_rdena++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      sh = '{8'h81, 8'h83, 8'h7A, 8'h7A, 8'h7D, 8'h7D, 8'hFF, 8'hFF};
   endtask

   function automatic logic is_f7_port(input logic [15:0] a);
      return (a[7:0] == 8'hF7) && (a[13:12] == 2'b11) && (a[10:8] == 3'b111);
   endfunction

   // Holds the write for nz zpos periods, then checks strobe count, latency and latched values
   task automatic io_write(input logic [15:0] a, input logic [7:0] d, input logic m1,
                           input int nz, input logic map);
      int s0, c0, k, guard;
      logic expect_wr;
      expect_wr = is_f7_port(a) && m1;
      @(negedge fclk);
      za = a; zd = d; m1_n = m1; pent1m_ROM = map; iorq_n = 1'b0; wr_n = 1'b0;
      s0 = n_strobe; c0 = -1; k = 0; guard = 0;
      while (k < nz && guard < 100) begin
         @(posedge fclk); #1;
         guard++;
         if (zpos) begin
            if (c0 < 0) c0 = cyc;
            k++;
         end
      end
      @(negedge fclk);
      iorq_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
      repeat (12) @(negedge fclk);
      chk("wr_zpos_timeout", guard < 100, 1);
      if (expect_wr) begin
         sh[{a[15:14], map}] = d;
         chk("wr_count", n_strobe - s0, 1);
         chk("wr_latency", strobe_cyc, c0 + 2);
         chk("wr_addr", f7_addr, a);
         chk("wr_data", f7_data, d);
      end else begin
         chk("nowr_count", n_strobe - s0, 0);
      end
   endtask

   task automatic io_read(input logic [1:0] w, input logic map, input logic en, input logic xt);
      int s0;
      @(negedge fclk);
      za = {w, 2'b11, xt, 3'b111, 8'hF7};
      pent1m_ROM = map; shadow_en = en; iorq_n = 1'b0; rd_n = 1'b0; s0 = n_strobe;
      @(posedge fclk);
      @(posedge fclk); #1;
      chk("rd_ena", rd_ena, en);
      chk("rd_data", rd_data, sh[{w, map}]);
      @(negedge fclk);
      iorq_n = 1'b1; rd_n = 1'b1; shadow_en = 1'b0;
      repeat (3) @(negedge fclk);
      chk("rd_ena_off", rd_ena, 0);
      chk("rd_nostrobe", n_strobe - s0, 0);
   endtask

   task automatic read_all(input logic en);
      for (int i = 0; i < 8; i++) io_read(i[2:1], i[0], en, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge fclk);
      rst_n = 1'b0;
      repeat (3) @(negedge fclk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic reset_in_strobe();
      int s0, c0, k, guard;
      @(negedge fclk);
      za = 16'h7FF7; zd = 8'hC3; pent1m_ROM = 1'b1; iorq_n = 1'b0; wr_n = 1'b0;
      s0 = n_strobe; guard = 0;
      do begin
         @(posedge fclk); #1;
         guard++;
      end while (!zpos && guard < 20);
      @(posedge fclk); #1;
      rst_n = 1'b0;
      #1;
      chk("rst_wr", atmF7_wr, 0);
      chk("rst_addr", f7_addr, 16'h0000);
      chk("rst_data", f7_data, 8'h00);
      chk("rst_rd_data", rd_data, 8'h00);
      chk("rst_rd_ena", rd_ena, 0);
      repeat (3) @(negedge fclk);
      rst_n = 1'b1;
      model_reset();
      chk("rst_no_strobe", n_strobe - s0, 0);
      c0 = -1; k = 0;
      while (k < 3 && guard < 100) begin
         @(posedge fclk); #1;
         guard++;
         if (zpos) begin
            if (c0 < 0) c0 = cyc;
            k++;
         end
      end
      @(negedge fclk);
      iorq_n = 1'b1; wr_n = 1'b1;
      repeat (12) @(negedge fclk);
      sh[3'b011] = 8'hC3;
      chk("rst_guard", guard < 100, 1);
      chk("post_rst_count", n_strobe - s0, 1);
      chk("post_rst_latency", strobe_cyc, c0 + 2);
      chk("post_rst_addr", f7_addr, 16'h7FF7);
      chk("post_rst_data", f7_data, 8'hC3);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rd0, r;
      logic [15:0] a;
      model_reset();
      repeat (3) @(negedge fclk);
      chk("reset_wr", atmF7_wr, 0);
      chk("reset_addr", f7_addr, 16'h0000);
      chk("reset_data", f7_data, 8'h00);
      chk("reset_rd_data", rd_data, 8'h00);
      chk("reset_rd_ena", rd_ena, 0);
      rst_n = 1'b1;

      io_write(16'h3FF7, 8'h3A, 1'b1, 1, 1'b0);
      io_read(2'd0, 1'b0, 1'b1, 1'b1);
      io_write(16'h7FF7, 8'h55, 1'b1, 5, 1'b1);
      io_write(16'h77F7, 8'h66, 1'b1, 2, 1'b1);
      io_write(16'hB7F7, 8'h12, 1'b1, 2, 1'b1);
      io_read(2'd2, 1'b1, 1'b1, 1'b1);
      io_read(2'd2, 1'b0, 1'b1, 1'b1);

      do_reset();
      read_all(1'b1);
      rd0 = n_rdena;
      read_all(1'b0);
      chk("rd_ena_disabled", n_rdena - rd0, 0);

      io_write(16'h7FFD, 8'h10, 1'b1, 1, 1'b0);
      io_write(16'h3EF7, 8'h20, 1'b1, 1, 1'b0);
      io_write(16'h3FF7, 8'h30, 1'b0, 1, 1'b0);
      read_all(1'b1);

      for (int n = 0; n < 150; n++) begin
         r = $urandom_range(0, 9);
         if (r <= 4) begin
            a = {2'($urandom_range(0, 3)), 2'b11, 1'($urandom_range(0, 1)), 3'b111, 8'hF7};
            io_write(a, 8'($urandom), 1'b1, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
         end else if (r == 5) begin
            io_write(16'($urandom), 8'($urandom), 1'b1, 1, 1'($urandom_range(0, 1)));
         end else if (r == 6) begin
            io_write(16'hBFF7, 8'($urandom), 1'b0, 2, 1'($urandom_range(0, 1)));
         end else begin
            io_read(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
      end
      read_all(1'b1);

      reset_in_strobe();
      read_all(1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
